apb_master_arbiter: RTL and testbench

Two-requester arbiter sitting in front of the APB bridge master port (MREQ/MADDR/MWDATA/MSTRB/MWRITE/MPROT in, MREADY/MRDATA/MSLVERR back). It selects one requester at a time, round-robin by default, and registers that requester's command fields. It sequences the bridge through exactly one IDLE→SETUP→ACCESS transfer per grant, then returns read data and error status to the owning requester with a one-cycle done pulse.

---
 rtl/apb_master_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose:
//   Arbitrates two requesters onto a single APB bridge master port. One
//   requester is granted at a time and its command is registered onto M*. The
//   bridge is then walked through exactly one IDLE->SETUP->ACCESS transfer.
//   The read data and slave error come back to the owner together with a
//   one-cycle done pulse.
//
//   Arbitration is round-robin by default. When APB_ARB_FIXED_PRIO_EN is
//   defined, R0 always wins a tie. LAST is still tracked in that build but is
//   not used.
//
// Ports:
//   PCLK, PRESET            clock; asynchronous active-high reset
//   Rx_REQ / Rx_ADDR / Rx_WDATA / Rx_STRB / Rx_WRITE / Rx_PROT
//                           requester command, held until Rx_DONE
//   Rx_GNT                  requester owns the bridge (REQ through DONE)
//   Rx_DONE                 one-cycle completion pulse
//   R_RDATA, R_SLVERR       result of the last completed transfer
//   MREQ                    one-cycle request pulse to the bridge
//   MADDR/MWDATA/MSTRB/MWRITE/MPROT
//                           registered command of the granted requester
//   MREADY, MRDATA, MSLVERR bridge completion handshake and response
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STROBE_WIDTH = DATA_WIDTH / 8,
   parameter int PROT_WIDTH   = 3
) (
   input  logic                    PCLK,
   input  logic                    PRESET,

   input  logic                    R0_REQ,
   input  logic [ADDR_WIDTH-1:0]   R0_ADDR,
   input  logic [DATA_WIDTH-1:0]   R0_WDATA,
   input  logic [STROBE_WIDTH-1:0] R0_STRB,
   input  logic                    R0_WRITE,
   input  logic [PROT_WIDTH-1:0]   R0_PROT,

   input  logic                    R1_REQ,
   input  logic [ADDR_WIDTH-1:0]   R1_ADDR,
   input  logic [DATA_WIDTH-1:0]   R1_WDATA,
   input  logic [STROBE_WIDTH-1:0] R1_STRB,
   input  logic                    R1_WRITE,
   input  logic [PROT_WIDTH-1:0]   R1_PROT,

   output logic                    R0_GNT,
   output logic                    R1_GNT,
   output logic                    R0_DONE,
   output logic                    R1_DONE,
   output logic [DATA_WIDTH-1:0]   R_RDATA,
   output logic                    R_SLVERR,

   output logic                    MREQ,
   output logic [ADDR_WIDTH-1:0]   MADDR,
   output logic [DATA_WIDTH-1:0]   MWDATA,
   output logic [STROBE_WIDTH-1:0] MSTRB,
   output logic                    MWRITE,
   output logic [PROT_WIDTH-1:0]   MPROT,
   input  logic                    MREADY,
   input  logic [DATA_WIDTH-1:0]   MRDATA,
   input  logic                    MSLVERR
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE
   } state_t;

   state_t                  state_q,  state_d;
   logic                    last_q,   last_d;
   logic [1:0]              gnt_q,    gnt_d;
   logic [1:0]              done_q,   done_d;
   logic                    mreq_q,   mreq_d;
   logic [ADDR_WIDTH-1:0]   maddr_q,  maddr_d;
   logic [DATA_WIDTH-1:0]   mwdata_q, mwdata_d;
   logic [STROBE_WIDTH-1:0] mstrb_q,  mstrb_d;
   logic                    mwrite_q, mwrite_d;
   logic [PROT_WIDTH-1:0]   mprot_q,  mprot_d;
   logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
   logic                    slverr_q, slverr_d;

   logic [1:0]              eligible;
   logic                    sel;

   // A requester whose done pulse is high this cycle is still holding the old
   // command, so it is masked. This prevents the same command being issued twice.
   always_comb begin
      eligible = {R1_REQ & ~done_q[1], R0_REQ & ~done_q[0]};
      if (&eligible) begin
`ifdef APB_ARB_FIXED_PRIO_EN
         sel = 1'b0;
`else
         sel = ~last_q;
`endif
      end else begin
         sel = eligible[1];
      end
   end

   // NOTE: every signal this block drives gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      mreq_d   = 1'b0;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      mstrb_d  = mstrb_q;
      mwrite_d = mwrite_q;
      mprot_d  = mprot_q;
      rdata_d  = rdata_q;
      slverr_d = slverr_q;

      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               gnt_d    = sel ? 2'b10 : 2'b01;
               last_d   = sel;
               mreq_d   = 1'b1;
               maddr_d  = sel ? R1_ADDR  : R0_ADDR;
               mwdata_d = sel ? R1_WDATA : R0_WDATA;
               mstrb_d  = sel ? R1_STRB  : R0_STRB;
               mwrite_d = sel ? R1_WRITE : R0_WRITE;
               mprot_d  = sel ? R1_PROT  : R0_PROT;
               state_d  = ST_REQ;
            end
         end
         ST_REQ:    state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: begin
            // MREQ stays low here, so the bridge falls back to its IDLE
            // after this single transfer.
            if (MREADY) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // The bridge presents the read data in the cycle after MREADY.
            // That cycle is this one.
            rdata_d  = MRDATA;
            slverr_d = MSLVERR;
            done_d   = gnt_q;
            gnt_d    = '0;
            state_d  = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so that every flop
   // samples the values from before the edge, whatever order the statements
   // are written in.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         gnt_q    <= '0;
         done_q   <= '0;
         mreq_q   <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mstrb_q  <= '0;
         mwrite_q <= 1'b0;
         mprot_q  <= '0;
         rdata_q  <= '0;
         slverr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         mreq_q   <= mreq_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mstrb_q  <= mstrb_d;
         mwrite_q <= mwrite_d;
         mprot_q  <= mprot_d;
         rdata_q  <= rdata_d;
         slverr_q <= slverr_d;
      end
   end

   assign R0_GNT   = gnt_q[0];
   assign R1_GNT   = gnt_q[1];
   assign R0_DONE  = done_q[0];
   assign R1_DONE  = done_q[1];
   assign R_RDATA  = rdata_q;
   assign R_SLVERR = slverr_q;
   assign MREQ     = mreq_q;
   assign MADDR    = maddr_q;
   assign MWDATA   = mwdata_q;
   assign MSTRB    = mstrb_q;
   assign MWRITE   = mwrite_q;
   assign MPROT    = mprot_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// This bench has three kinds of process:
//   - Requester drivers issue random or directed commands.
//   - A bridge model answers each MREQ pulse with a chosen number of wait
//     states, read data and an error flag. It also drives spurious MREADY
//     while no ACCESS is in progress.
//   - A monitor runs on every falling edge.
//
// The monitor predicts the grantee from the requests that were visible in the
// previous cycle, using the round-robin rule or the fixed-priority rule. On
// every MREQ it pushes the expected completion into a scoreboard. Every done
// pulse pops one entry and compares it.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int PW = 3;

   typedef struct {
      int            idx;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   typedef struct {
      int            waits;
      logic [DW-1:0] rdata;
      logic          err;
   } job_t;

   logic          PCLK   = 1'b0;
   logic          PRESET = 1'b1;

   logic          req   [2];
   logic [AW-1:0] addr  [2];
   logic [DW-1:0] wdata [2];
   logic [SW-1:0] strb  [2];
   logic          wr    [2];
   logic [PW-1:0] prot  [2];

   wire  [1:0]    gnt;
   wire  [1:0]    done;
   wire  [DW-1:0] R_RDATA;
   wire           R_SLVERR;
   wire           MREQ;
   wire  [AW-1:0] MADDR;
   wire  [DW-1:0] MWDATA;
   wire  [SW-1:0] MSTRB;
   wire           MWRITE;
   wire  [PW-1:0] MPROT;
   logic          MREADY  = 1'b0;
   logic [DW-1:0] MRDATA  = '0;
   logic          MSLVERR = 1'b0;

   int            tests = 0;
   int            fails = 0;

   exp_t          sb_q  [$];
   job_t          job_q [$];
   int            grant_log [$];

   bit            f_valid     = 1'b0;
   job_t          f_job;
   bit            spur_force  = 1'b0;
   bit            log_grants  = 1'b0;

   apb_master_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW), .PROT_WIDTH(PW)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .R0_REQ(req[0]), .R0_ADDR(addr[0]), .R0_WDATA(wdata[0]), .R0_STRB(strb[0]),
      .R0_WRITE(wr[0]), .R0_PROT(prot[0]),
      .R1_REQ(req[1]), .R1_ADDR(addr[1]), .R1_WDATA(wdata[1]), .R1_STRB(strb[1]),
      .R1_WRITE(wr[1]), .R1_PROT(prot[1]),
      .R0_GNT(gnt[0]), .R1_GNT(gnt[1]), .R0_DONE(done[0]), .R1_DONE(done[1]),
      .R_RDATA(R_RDATA), .R_SLVERR(R_SLVERR),
      .MREQ(MREQ), .MADDR(MADDR), .MWDATA(MWDATA), .MSTRB(MSTRB),
      .MWRITE(MWRITE), .MPROT(MPROT),
      .MREADY(MREADY), .MRDATA(MRDATA), .MSLVERR(MSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic [1:0]    prev_elig = '0;
   logic          prev_mreq = 1'b0;
   int            last_m    = 1;
   int            cap_g     = 0;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_wdata;
   logic [SW-1:0] cap_strb;
   logic          cap_wr;
   logic [PW-1:0] cap_prot;

   always @(negedge PCLK) begin
      int   g;
      exp_t e;
      job_t j;
      if (PRESET) begin
         prev_elig = '0;
         prev_mreq = 1'b0;
         last_m    = 1;
         sb_q.delete();
         job_q.delete();
      end else begin
         check("gnt_onehot", gnt[0] & gnt[1], 1'b0);
         if (done != 2'b00) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", done, 2'b00);
            end else begin
               e = sb_q.pop_front();
               check("done_idx", done, (e.idx == 1) ? 2'b10 : 2'b01);
               check("r_rdata", R_RDATA, e.rdata);
               check("r_slverr", R_SLVERR, e.err);
            end
         end
         check("mreq_single_cycle", MREQ & prev_mreq, 1'b0);
         if (MREQ) begin
            check("mreq_has_requester", prev_elig != 2'b00, 1'b1);
            if (prev_elig == 2'b11) begin
`ifdef APB_ARB_FIXED_PRIO_EN
               g = 0;
`else
               g = (last_m == 0) ? 1 : 0;
`endif
            end else begin
               g = prev_elig[1] ? 1 : 0;
            end
            last_m = g;
            check("grant", gnt, (g == 1) ? 2'b10 : 2'b01);
            check("maddr", MADDR, addr[g]);
            check("mcmd", {MWDATA, MSTRB, MWRITE, MPROT}, {wdata[g], strb[g], wr[g], prot[g]});
            if (log_grants) grant_log.push_back(g);
            cap_g = g;
            cap_addr = MADDR; cap_wdata = MWDATA; cap_strb = MSTRB; cap_wr = MWRITE; cap_prot = MPROT;
            if (f_valid) begin
               j = f_job;
               f_valid = 1'b0;
            end else begin
               j.waits = $urandom_range(0, 3);
               j.rdata = $urandom;
               j.err   = ($urandom_range(0, 3) == 0);
            end
            job_q.push_back(j);
            e.idx = g; e.rdata = j.rdata; e.err = j.err;
            sb_q.push_back(e);
         end else if (gnt != 2'b00) begin
            check("gnt_hold", gnt, (cap_g == 1) ? 2'b10 : 2'b01);
            check("m_stable", {MADDR, MWDATA, MSTRB, MWRITE, MPROT},
                  {cap_addr, cap_wdata, cap_strb, cap_wr, cap_prot});
         end
         prev_mreq = MREQ;
         prev_elig = {req[1] & ~done[1], req[0] & ~done[0]};
      end
   end

   // ----------------------------------------------------------- bridge model
   // Phases: 0 idle, 1 req, 2 setup, 3 access, 4 response cycle.
   int   bph = 0;
   int   wl  = 0;
   job_t cur;

   always begin
      @(posedge PCLK);
      #1;
      if (PRESET) begin
         bph    = 0;
         MREADY = 1'b0;
      end else begin
         case (bph)
            1: bph = 2;
            2: begin
               bph = 3;
               if (job_q.size() != 0) cur = job_q.pop_front();
               else begin cur.waits = 0; cur.rdata = '0; cur.err = 1'b0; end
               wl = cur.waits;
            end
            3: if (MREADY) bph = 4;
            default: bph = MREQ ? 1 : 0;
         endcase
         case (bph)
            3: begin
               MREADY  = (wl == 0);
               MSLVERR = (wl == 0) ? cur.err : 1'($urandom);
               MRDATA  = $urandom;
               if (wl > 0) wl--;
            end
            4: begin
               MRDATA  = cur.rdata;
               MSLVERR = cur.err;
               MREADY  = spur_force ? 1'b1 : 1'($urandom);
            end
            default: begin
               MREADY  = spur_force ? 1'b1 : 1'($urandom);
               MRDATA  = $urandom;
               MSLVERR = 1'($urandom);
            end
         endcase
      end
   end

   // -------------------------------------------------------------- stimulus
   task automatic directed(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic w, input int waits,
                           input logic [DW-1:0] rd, input logic err, input int exp_done);
      int c, mreq_c, done_c;
      f_job.waits = waits; f_job.rdata = rd; f_job.err = err;
      f_valid = 1'b1;
      @(posedge PCLK);
      #1;
      addr[i] = a; wdata[i] = d; strb[i] = s; wr[i] = w; prot[i] = 3'(i + 1);
      req[i]  = 1'b1;
      c = 0; mreq_c = -1; done_c = -1;
      while (c < 60 && done_c < 0) begin
         @(posedge PCLK);
         #1;
         c++;
         if (MREQ && mreq_c < 0) mreq_c = c;
         if (done[i]) done_c = c;
      end
      req[i] = 1'b0;
      check("mreq_cycle", mreq_c, 1);
      check("done_cycle", done_c, exp_done);
   endtask

   task automatic run_req(input int i, input int n, input bit cont);
      int t;
      @(posedge PCLK);
      #1;
      for (int k = 0; k < n; k++) begin
         if (!req[i] && !cont) begin
            repeat ($urandom_range(0, 3)) begin @(posedge PCLK); #1; end
         end
         addr[i]  = cont ? ((i == 1) ? 32'h24 : 32'h08) : ($urandom & 32'hFFFF_FFFC);
         wdata[i] = $urandom;
         strb[i]  = 4'($urandom);
         wr[i]    = 1'($urandom);
         prot[i]  = 3'($urandom);
         req[i]   = 1'b1;
         t = 0;
         do begin
            @(posedge PCLK);
            #1;
            t++;
         end while (!done[i] && t < 200);
         if (!done[i]) begin
            check("req_timeout", done[i], 1'b1);
            req[i] = 1'b0;
            return;
         end
         if (k == n - 1 || (!cont && $urandom_range(0, 1) == 1)) req[i] = 1'b0;
      end
   endtask

   task automatic drain();
      repeat (12) @(posedge PCLK);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; strb[i] = '0; wr[i] = 1'b0; prot[i] = '0;
      end
      repeat (3) @(posedge PCLK);
      #1;
      check("reset_outputs",
            {gnt, done, MREQ, MADDR, MWDATA, MSTRB, MWRITE, MPROT, R_RDATA, R_SLVERR}, '0);
      PRESET = 1'b0;
      repeat (2) @(posedge PCLK);

      // Single zero-wait read.
      directed(0, 32'h04, 32'h0, 4'h0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 5);
      drain();
      // Write with three wait states.
      directed(1, 32'h20, 32'h1234_5678, 4'hF, 1'b1, 3, 32'h0BAD_F00D, 1'b0, 8);
      drain();
      // Slave error, then an error-free transfer.
      directed(0, 32'h40, 32'h0, 4'h0, 1'b0, 1, 32'hCAFE_0001, 1'b1, 6);
      directed(1, 32'h44, 32'h0, 4'h0, 1'b0, 0, 32'hCAFE_0002, 1'b0, 5);
      drain();

      // MREADY stuck high outside ACCESS: no request, and none of IDLE, REQ
      // or SETUP may advance on it.
      spur_force = 1'b1;
      c = 0;
      repeat (10) begin
         @(posedge PCLK);
         #1;
         if (MREQ) c++;
      end
      check("spurious_no_mreq", c, 0);
      directed(0, 32'h50, 32'h0, 4'h0, 1'b0, 2, 32'h5A5A_5A5A, 1'b0, 7);
      spur_force = 1'b0;
      drain();

      // Both requesters hold their requests continuously.
      log_grants = 1'b1;
      fork
         run_req(0, 6, 1'b1);
         run_req(1, 6, 1'b1);
      join
      log_grants = 1'b0;
      drain();
      check("contention_count", grant_log.size(), 12);
      for (int k = 1; k < grant_log.size(); k++) begin
         check("contention_alternate", grant_log[k] != grant_log[k-1], 1'b1);
      end

      // Random traffic.
      fork
         run_req(0, 20, 1'b0);
         run_req(1, 20, 1'b0);
      join
      drain();

      // Reset while the bridge is inserting wait states.
      f_job.waits = 20; f_job.rdata = 32'h1111_2222; f_job.err = 1'b0;
      f_valid = 1'b1;
      @(posedge PCLK);
      #1;
      addr[0] = 32'h60; wr[0] = 1'b0; req[0] = 1'b1;
      c = 0;
      while (!MREQ && c < 20) begin @(posedge PCLK); #1; c++; end
      check("reset_test_mreq", MREQ, 1'b1);
      repeat (5) @(posedge PCLK);
      #3;
      PRESET = 1'b1;
      #1;
      check("async_reset_outputs",
            {gnt, done, MREQ, MADDR, MWDATA, MSTRB, MWRITE, MPROT, R_RDATA, R_SLVERR}, '0);
      req[0] = 1'b0;
      f_valid = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      c = 0;
      repeat (10) begin
         @(posedge PCLK);
         #1;
         if (done != 2'b00) c++;
      end
      check("no_done_after_abort", c, 0);
      directed(0, 32'h04, 32'h0, 4'h0, 1'b0, 0, 32'h7777_8888, 1'b0, 5);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
